scan_decoder: RTL and testbench



---
 rtl/scan_pkg.sv | 25 ++
 rtl/dec_onehot_low.sv | 24 ++
 rtl/scan_decoder.sv | 139 +++++++++++++
 tb/tb_scan_decoder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// scan_pkg
// Shared definitions for the scan decoder slice: the FSM state encoding and
// the active-low one-hot helper used by the parametrised decoder.
// No ports; imported with import scan_pkg::*.
package scan_pkg;

  // Widest select the helper supports (2**5 = 32 output lines).
  localparam int MAX_SEL_W = 5;

  // FSM states of scan_decoder. IDLE and BLANK keep every line inactive,
  // DIRECT and DWELL drive exactly one line low.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIRECT = 2'd1,
    S_DWELL  = 2'd2,
    S_BLANK  = 2'd3
  } state_t;

  // Returns ~(1 << sel) at full 32-bit width; callers truncate to their
  // own output count.
  function automatic logic [31:0] onehot_low(input logic [MAX_SEL_W-1:0] sel);
    return ~(32'd1 << sel);
  endfunction

endpackage

// File: rtl/dec_onehot_low.sv
// dec_onehot_low
// Purely combinational SEL_W -> 2**SEL_W active-low decoder with enable.
// Generalises the old fixed 2-to-4 active-low decoder.
// Ports:
//   i_en   in  1            high: decode i_sel; low: all outputs high
//   i_sel  in  SEL_W        line to pull low
//   o_y    out 2**SEL_W     active-low one-hot lines
module dec_onehot_low
  import scan_pkg::*;
#(
  parameter int SEL_W = 2
) (
  input  logic                  i_en,
  input  logic [SEL_W-1:0]      i_sel,
  output logic [(2**SEL_W)-1:0] o_y
);

  localparam int N = 2 ** SEL_W;

  // The helper works at 32 bits; the select is widened and the result cut
  // back to the N lines this instance owns.
  assign o_y = i_en ? N'(onehot_low(MAX_SEL_W'(i_sel))) : '1;

endmodule

// File: rtl/scan_decoder.sv
// scan_decoder
// Registered active-low one-of-N decoder with two modes: direct decode of an
// external address, or an autonomous scan across all lines with a
// programmable dwell and a fixed blanking gap between channels.
// Ports:
//   clk      in  1        rising-edge clock
//   rst      in  1        synchronous active-high reset
//   en       in  1        global enable; low forces all lines inactive
//   mode     in  1        0 = direct decode of addr, 1 = scan
//   addr     in  SEL_W    select used in direct mode
//   div      in  DIV_W    dwell length minus one, sampled on dwell entry
//   y        out 2**SEL_W active-low decoded lines, registered
//   cur_sel  out SEL_W    index currently (or last) decoded
//   wrap     out 1        one-cycle pulse when the scan returns to line 0
// SEL_W is intended for 1..5.
module scan_decoder
  import scan_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int DIV_W = 16,
  parameter int BLANK = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      addr,
  input  logic [DIV_W-1:0]      div,
  output logic [(2**SEL_W)-1:0] y,
  output logic [SEL_W-1:0]      cur_sel,
  output logic                  wrap
);

  localparam int N       = 2 ** SEL_W;
  localparam int BLANK_W = (BLANK > 1) ? $clog2(BLANK) : 1;
  // Blank counter counts BLANK-1 down to 0, giving BLANK idle cycles.
  localparam logic [BLANK_W-1:0] BLANK_LOAD = (BLANK > 0) ? BLANK_W'(BLANK - 1) : '0;

  state_t             r_state;
  logic [SEL_W-1:0]   r_sel;
  logic               r_wrap;
  logic [DIV_W-1:0]   r_dwell;
  logic [BLANK_W-1:0] r_blank;
  logic [N-1:0]       r_y;

  state_t             w_nextState;
  logic [SEL_W-1:0]   w_nextSel;
  logic               w_nextWrap;
  logic [DIV_W-1:0]   w_nextDwell;
  logic [BLANK_W-1:0] w_nextBlank;
  logic               w_active;
  logic [N-1:0]       w_nextY;

  // Next-state logic. Enable beats mode, mode beats the scan sequence, so a
  // switch to direct mode or a disable takes effect on the very next edge
  // whatever the scan was doing. Advancing the channel relies on the
  // natural SEL_W-bit rollover, which is exactly modulo N.
  always_comb begin
    w_nextState = r_state;
    w_nextSel   = r_sel;
    w_nextWrap  = 1'b0;
    w_nextDwell = r_dwell;
    w_nextBlank = r_blank;
    if (!en) begin
      w_nextState = S_IDLE;
    end else if (!mode) begin
      w_nextState = S_DIRECT;
      w_nextSel   = addr;
    end else begin
      unique case (r_state)
        S_IDLE, S_DIRECT: begin
          w_nextState = S_DWELL;
          w_nextDwell = div;
        end
        S_DWELL: begin
          if (r_dwell != '0) begin
            w_nextDwell = r_dwell - DIV_W'(1);
          end else if (BLANK > 0) begin
            w_nextState = S_BLANK;
            w_nextBlank = BLANK_LOAD;
          end else begin
            w_nextSel   = r_sel + SEL_W'(1);
            w_nextWrap  = (r_sel == SEL_W'(N - 1));
            w_nextDwell = div;
          end
        end
        S_BLANK: begin
          if (r_blank != '0) begin
            w_nextBlank = r_blank - BLANK_W'(1);
          end else begin
            w_nextState = S_DWELL;
            w_nextSel   = r_sel + SEL_W'(1);
            w_nextWrap  = (r_sel == SEL_W'(N - 1));
            w_nextDwell = div;
          end
        end
        default: w_nextState = S_IDLE;
      endcase
    end
  end

  // The output lines are decoded from the next state and select, then
  // registered together with them, so y always agrees with state/cur_sel and
  // can never show two low bits during a transition.
  assign w_active = (w_nextState == S_DIRECT) || (w_nextState == S_DWELL);

  dec_onehot_low #(
    .SEL_W (SEL_W)
  ) u_dec (
    .i_en  (w_active),
    .i_sel (w_nextSel),
    .o_y   (w_nextY)
  );

  // State, counters and all outputs share one register stage; reset wins
  // over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_wrap  <= 1'b0;
      r_dwell <= '0;
      r_blank <= '0;
      r_y     <= '1;
    end else begin
      r_state <= w_nextState;
      r_sel   <= w_nextSel;
      r_wrap  <= w_nextWrap;
      r_dwell <= w_nextDwell;
      r_blank <= w_nextBlank;
      r_y     <= w_nextY;
    end
  end

  assign y       = r_y;
  assign cur_sel = r_sel;
  assign wrap    = r_wrap;

endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder
// Drives two scan_decoder instances (SEL_W=2): dutA with BLANK=2 and dutB
// with BLANK=0. Each stimulus cycle pushes the outputs expected after the
// next clock edge onto that instance's queue; a monitor per instance pops
// and compares one entry just after every rising edge.
module tb_scan_decoder;

  typedef struct {
    logic [3:0] y;
    logic [1:0] sel;
    logic       wrap;
  } exp_t;

  logic        clk = 1'b0;
  logic [1:0]  addr = '0;

  logic        rstA = 1'b1, enA = 1'b0, modeA = 1'b0;
  logic [15:0] divA = '0;
  logic [3:0]  yA;
  logic [1:0]  selA;
  logic        wrapA;

  logic        rstB = 1'b1, enB = 1'b0, modeB = 1'b0;
  logic [15:0] divB = '0;
  logic [3:0]  yB;
  logic [1:0]  selB;
  logic        wrapB;

  exp_t qA[$];
  exp_t qB[$];

  int checks = 0;
  int errors = 0;

  // 10-unit clock period.
  always #5 clk = ~clk;

  scan_decoder #(.SEL_W(2), .DIV_W(16), .BLANK(2)) dutA (
    .clk(clk), .rst(rstA), .en(enA), .mode(modeA), .addr(addr), .div(divA),
    .y(yA), .cur_sel(selA), .wrap(wrapA)
  );

  scan_decoder #(.SEL_W(2), .DIV_W(16), .BLANK(0)) dutB (
    .clk(clk), .rst(rstB), .en(enB), .mode(modeB), .addr(addr), .div(divB),
    .y(yB), .cur_sel(selB), .wrap(wrapB)
  );

  // Single point of comparison: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, observed, expected);
    end
  endtask

  // Active-low one-hot pattern for a 4-line decoder.
  function automatic logic [3:0] ohl(input int ch);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << ch);
  endfunction

  // Drives one cycle of inputs for the chosen instance, queues what that
  // instance should show after the coming edge, then waits a full cycle.
  task automatic applyStimulus(input bit which, input logic r, input logic e,
                               input logic m, input logic [1:0] a,
                               input logic [15:0] d, input logic [3:0] ey,
                               input int es, input logic ew);
    exp_t x;
    x.y    = ey;
    x.sel  = 2'(es);
    x.wrap = ew;
    addr = a;
    if (!which) begin
      rstA = r; enA = e; modeA = m; divA = d;
      qA.push_back(x);
    end else begin
      rstB = r; enB = e; modeB = m; divB = d;
      qB.push_back(x);
    end
    @(negedge clk);
  endtask

  // Monitors sample 1 unit after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (qA.size() > 0) begin
      e = qA.pop_front();
      checkOutput("A.y", 32'(yA), 32'(e.y));
      checkOutput("A.cur_sel", 32'(selA), 32'(e.sel));
      checkOutput("A.wrap", 32'(wrapA), 32'(e.wrap));
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (qB.size() > 0) begin
      e = qB.pop_front();
      checkOutput("B.y", 32'(yB), 32'(e.y));
      checkOutput("B.cur_sel", 32'(selB), 32'(e.sel));
      checkOutput("B.wrap", 32'(wrapB), 32'(e.wrap));
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish before t=100000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    @(negedge clk);

    // Reset held with en/mode active, then released with en low.
    applyStimulus(0, 1, 1, 1, 0, 3, 4'b1111, 0, 0);
    applyStimulus(0, 1, 1, 1, 0, 3, 4'b1111, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 3, 4'b1111, 0, 0);

    // Direct decode, one-cycle latency; disable blanks all lines.
    applyStimulus(0, 0, 1, 0, 2, 3, 4'b1011, 2, 0);
    applyStimulus(0, 0, 1, 0, 3, 3, 4'b0111, 3, 0);
    applyStimulus(0, 0, 0, 0, 3, 3, 4'b1111, 3, 0);
    applyStimulus(0, 0, 1, 0, 0, 3, 4'b1110, 0, 0);

    // Two full scan frames with div=3 (4 dwell + 2 blank per channel),
    // then the first cycle of the third frame carries wrap.
    for (int f = 0; f < 2; f++) begin
      for (int ch = 0; ch < 4; ch++) begin
        for (int c = 0; c < 4; c++)
          applyStimulus(0, 0, 1, 1, 0, 3, ohl(ch), ch, (f > 0 && ch == 0 && c == 0));
        for (int b = 0; b < 2; b++)
          applyStimulus(0, 0, 1, 1, 0, 3, 4'b1111, ch, 0);
      end
    end
    applyStimulus(0, 0, 1, 1, 0, 3, 4'b1110, 0, 1);
    applyStimulus(0, 0, 1, 0, 0, 3, 4'b1110, 0, 0);

    // div 3 -> 7 mid-dwell: channel 0 keeps 4 cycles, channel 1 gets 8.
    applyStimulus(0, 0, 1, 1, 0, 3, 4'b1110, 0, 0);
    for (int c = 0; c < 3; c++) applyStimulus(0, 0, 1, 1, 0, 7, 4'b1110, 0, 0);
    for (int b = 0; b < 2; b++) applyStimulus(0, 0, 1, 1, 0, 7, 4'b1111, 0, 0);
    for (int c = 0; c < 8; c++) applyStimulus(0, 0, 1, 1, 0, 7, 4'b1101, 1, 0);
    applyStimulus(0, 0, 1, 0, 1, 7, 4'b1101, 1, 0);

    // Abort on channel 1 after 2 dwell cycles, 5 disabled cycles, resume
    // with a full 4-cycle dwell on the same channel.
    for (int c = 0; c < 2; c++) applyStimulus(0, 0, 1, 1, 1, 3, 4'b1101, 1, 0);
    for (int c = 0; c < 5; c++) applyStimulus(0, 0, 0, 1, 1, 3, 4'b1111, 1, 0);
    for (int c = 0; c < 4; c++) applyStimulus(0, 0, 1, 1, 1, 3, 4'b1101, 1, 0);
    for (int b = 0; b < 2; b++) applyStimulus(0, 0, 1, 1, 1, 3, 4'b1111, 1, 0);
    for (int c = 0; c < 4; c++) applyStimulus(0, 0, 1, 1, 1, 3, 4'b1011, 2, 0);
    applyStimulus(0, 0, 1, 1, 1, 3, 4'b1111, 2, 0);

    // Switch to direct mid-blank: addr 0 shows on the next edge.
    applyStimulus(0, 0, 1, 0, 0, 3, 4'b1110, 0, 0);

    // Reset mid-dwell overrides en/mode.
    applyStimulus(0, 0, 1, 0, 2, 3, 4'b1011, 2, 0);
    for (int c = 0; c < 2; c++) applyStimulus(0, 0, 1, 1, 2, 3, 4'b1011, 2, 0);
    for (int c = 0; c < 2; c++) applyStimulus(0, 1, 1, 1, 2, 3, 4'b1111, 0, 0);
    applyStimulus(0, 0, 1, 1, 2, 3, 4'b1110, 0, 0);
    applyStimulus(0, 0, 0, 1, 2, 3, 4'b1111, 0, 0);

    // BLANK=0, div=0: one line per cycle, wrap every 4th cycle.
    applyStimulus(1, 1, 0, 1, 0, 0, 4'b1111, 0, 0);
    for (int k = 0; k < 12; k++)
      applyStimulus(1, 0, 1, 1, 0, 0, ohl(k % 4), k % 4, (k % 4 == 0 && k > 0));

    // Every queued expectation must have been consumed.
    @(negedge clk);
    checkOutput("drainA", 32'(qA.size()), 32'd0);
    checkOutput("drainB", 32'(qB.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
